// File: rtl/rps_pkg.sv
// Shared choice/result encodings, FSM state type and judge-code helpers for
// the rock-paper-scissors match scorekeeper.
package rps_pkg;

  localparam int unsigned CODE_W  = 3;
  localparam int unsigned STATE_W = 3;

  typedef logic [CODE_W-1:0]  code_t;
  typedef logic [STATE_W-1:0] state_t;

  localparam code_t ROCK      = 3'b001;
  localparam code_t SCISSORS  = 3'b010;
  localparam code_t PAPER     = 3'b100;
  localparam code_t EMPTY     = 3'b000;

  localparam code_t P1_WIN    = 3'b100;
  localparam code_t P2_WIN    = 3'b001;
  localparam code_t DRAW      = 3'b010;
  localparam code_t NO_WINNER = 3'b000;

  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_ARMED      = 3'd1;
  localparam state_t ST_SHOW       = 3'd2;
  localparam state_t ST_WAIT_CLEAR = 3'd3;
  localparam state_t ST_DONE       = 3'd4;

  // Judge codes outside the three legal results read as "no result".
  function automatic code_t sanitize_code(input code_t c);
    case (c)
      P1_WIN, P2_WIN, DRAW: sanitize_code = c;
      default:              sanitize_code = NO_WINNER;
    endcase
  endfunction

  function automatic logic is_choice(input code_t c);
    return (c == ROCK) || (c == SCISSORS) || (c == PAPER);
  endfunction

  // Result code a judge would produce for one pair of player choices.
  function automatic code_t judge(input code_t p1, input code_t p2);
    if (p1 == EMPTY || p2 == EMPTY || !is_choice(p1) || !is_choice(p2))
      return NO_WINNER;
    else if (p1 == p2)
      return DRAW;
    else if ((p1 == ROCK && p2 == SCISSORS) || (p1 == SCISSORS && p2 == PAPER) ||
             (p1 == PAPER && p2 == ROCK))
      return P1_WIN;
    else
      return P2_WIN;
  endfunction

endpackage

// File: rtl/rps_stable_detect.sv
// Debounces the judge code: a legal non-zero code held for STABLE_CYCLES
// consecutive enabled cycles produces a one-cycle accept pulse.
module rps_stable_detect
  import rps_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  en_i,
  input  code_t code_i,
  output logic  accept_c_o,
  output code_t code_c_o
);

  localparam int unsigned CNT_W = 8;

  code_t            code_s_c;
  code_t            last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, run_c;

  always_comb begin
    code_s_c = sanitize_code(code_i);
    run_c    = '0;
    if (code_s_c != NO_WINNER)
      run_c = (code_s_c == last_q) ? cnt_q + CNT_W'(1) : CNT_W'(1);
    accept_c_o = en_i && (run_c == CNT_W'(STABLE_CYCLES));
    code_c_o   = code_s_c;
    // Run length restarts whenever disabled or just accepted.
    if (!en_i || accept_c_o) begin
      cnt_d  = '0;
      last_d = NO_WINNER;
    end else begin
      cnt_d  = run_c;
      last_d = code_s_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      last_q <= NO_WINNER;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/rps_match_scorekeeper.sv
// Best-of-N rock-paper-scissors scorekeeper: debounced round acceptance,
// timed result display and match decision. Define RPS_DRAW_COUNT_EN to count draws.
module rps_match_scorekeeper
  import rps_pkg::*;
#(
  parameter int unsigned WIN_TARGET    = 2,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] winner_code,
  input  logic       match_start,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [4:0] round_cnt,
  output logic       show_result,
  output logic [2:0] round_result,
  output logic [2:0] match_winner,
  output logic [3:0] draw_cnt
);

  localparam int unsigned SCORE_W = 4;
  localparam int unsigned ROUND_W = 5;
  localparam int unsigned HOLD_W  = 26;

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic               show_q, show_d;
  code_t              result_q, result_d, winner_q, winner_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               det_en_c, accept_c;
  code_t              accept_code_c;
`ifdef RPS_DRAW_COUNT_EN
  logic [SCORE_W-1:0] draw_q, draw_d;
`endif

  // A start pulse always wins over a same-cycle acceptance.
  assign det_en_c = (state_q == ST_ARMED) && !match_start;

  rps_stable_detect #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_detect (
    .clk       (clk),
    .rst       (rst),
    .en_i      (det_en_c),
    .code_i    (winner_code),
    .accept_c_o(accept_c),
    .code_c_o  (accept_code_c)
  );

  always_comb begin
    state_d  = state_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    round_d  = round_q;
    show_d   = show_q;
    result_d = result_q;
    winner_d = winner_q;
    hold_d   = hold_q;
`ifdef RPS_DRAW_COUNT_EN
    draw_d   = draw_q;
`endif
    if (match_start) begin
      p1_d     = '0;
      p2_d     = '0;
      round_d  = '0;
      show_d   = 1'b0;
      result_d = NO_WINNER;
      winner_d = NO_WINNER;
      hold_d   = '0;
`ifdef RPS_DRAW_COUNT_EN
      draw_d   = '0;
`endif
      state_d  = ST_ARMED;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (accept_c) begin
            result_d = accept_code_c;
            show_d   = 1'b1;
            hold_d   = '0;
            state_d  = ST_SHOW;
            if (!(&round_q)) round_d = round_q + ROUND_W'(1);
            if (accept_code_c == P1_WIN && !(&p1_q)) p1_d = p1_q + SCORE_W'(1);
            if (accept_code_c == P2_WIN && !(&p2_q)) p2_d = p2_q + SCORE_W'(1);
`ifdef RPS_DRAW_COUNT_EN
            if (accept_code_c == DRAW && !(&draw_q)) draw_d = draw_q + SCORE_W'(1);
`endif
          end
        end
        ST_SHOW: begin
          if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
            show_d = 1'b0;
            if (p1_q == SCORE_W'(WIN_TARGET)) begin
              winner_d = P1_WIN;
              state_d  = ST_DONE;
            end else if (p2_q == SCORE_W'(WIN_TARGET)) begin
              winner_d = P2_WIN;
              state_d  = ST_DONE;
            end else begin
              state_d  = ST_WAIT_CLEAR;
            end
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        // Re-arm only once the judge has released its result.
        ST_WAIT_CLEAR: begin
          if (sanitize_code(winner_code) == NO_WINNER) state_d = ST_ARMED;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      p1_q     <= '0;
      p2_q     <= '0;
      round_q  <= '0;
      show_q   <= 1'b0;
      result_q <= NO_WINNER;
      winner_q <= NO_WINNER;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      round_q  <= round_d;
      show_q   <= show_d;
      result_q <= result_d;
      winner_q <= winner_d;
      hold_q   <= hold_d;
    end
  end

`ifdef RPS_DRAW_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) draw_q <= '0;
    else     draw_q <= draw_d;
  end
  assign draw_cnt = draw_q;
`else
  assign draw_cnt = '0;
`endif

  assign p1_score     = p1_q;
  assign p2_score     = p2_q;
  assign round_cnt    = round_q;
  assign show_result  = show_q;
  assign round_result = result_q;
  assign match_winner = winner_q;

endmodule
